// File: rtl/o_feature_writeback_pkg.sv
// Shared defaults and FSM state encoding for the feature writeback path.
package o_feature_writeback_pkg;

  localparam int FEATURE_WIDTH_DEF  = 16;
  localparam int SCALER_WIDTH_DEF   = 16;
  localparam int DATA_BUS_WIDTH_DEF = 128;
  localparam int ADDR_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_PACK  = 2'd1,
    WB_WRITE = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/o_feature_writeback_lane_packer.sv
// Packs LANES scaled words into one bus word, lane 0 in the low bits.
// Updates in the accepting cycle; full_o flags acceptance of the last lane (combinational).
module wb_lane_packer #(
  parameter int OW    = 32,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               accept_i,
  input  logic [OW-1:0]      word_i,
  output logic [LANES*OW-1:0] pack_o,
  output logic               full_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0]         lane_q;
  logic [LANES*OW-1:0]   pack_q;
  logic                  last_lane;

  assign last_lane = (lane_q == LW'(LANES - 1));
  assign full_o    = accept_i && last_lane;
  assign pack_o    = pack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
    end else if (accept_i) begin
      pack_q[int'(lane_q)*OW +: OW] <= word_i;
      lane_q <= last_lane ? '0 : lane_q + 1'b1;
    end
  end

endmodule

// File: rtl/o_feature_writeback.sv
// Writes packed CLP results to sequential external addresses; optional WB_PERF_CNT_EN adds a beat counter.
// Write request 1 cycle after last lane; holds data/address while o_mem_ready is low.
module o_feature_writeback
  import o_feature_writeback_pkg::*;
#(
  parameter int FEATURE_WIDTH  = FEATURE_WIDTH_DEF,
  parameter int SCALER_WIDTH   = SCALER_WIDTH_DEF,
  parameter int DATA_BUS_WIDTH = DATA_BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  localparam int OW            = FEATURE_WIDTH + SCALER_WIDTH,
  localparam int LANES         = DATA_BUS_WIDTH / OW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_enable,
  input  logic [ADDR_WIDTH-1:0]     dst_addr,
  input  logic [7:0]                wb_count,
  input  logic                      feature_valid,
  input  logic [OW-1:0]             scaled_feature,
  output logic                      feature_ready,
  output logic [DATA_BUS_WIDTH-1:0] o_data_bus_port,
  output logic [ADDR_WIDTH-1:0]     o_feature_addr,
  output logic                      o_feature_wr_en,
  input  logic                      o_mem_ready,
  output logic                      busy,
  output logic                      wb_done
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]               wb_beat_total
`endif
);

  wb_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              beats_q, beats_d;
  logic                    wb_done_q;
  logic                    pack_clear;
  logic                    pack_accept;
  logic                    pack_full;
  logic                    beat_acc;
  logic [LANES*OW-1:0]     pack_dat;

  assign pack_accept = feature_ready && feature_valid;

  wb_lane_packer #(
    .OW    (OW),
    .LANES (LANES)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (pack_clear),
    .accept_i (pack_accept),
    .word_i   (scaled_feature),
    .pack_o   (pack_dat),
    .full_o   (pack_full)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beats_d         = beats_q;
    pack_clear      = 1'b0;
    feature_ready   = 1'b0;
    o_feature_wr_en = 1'b0;
    o_data_bus_port = '0;
    o_feature_addr  = '0;
    beat_acc        = 1'b0;
    case (state_q)
      WB_IDLE: begin
        // The done-pulse cycle still counts as busy, so a start there is dropped.
        if (wb_enable && !wb_done_q) begin
          addr_d     = dst_addr;
          beats_d    = wb_count;
          pack_clear = 1'b1;
          state_d    = (wb_count != 8'd0) ? WB_PACK : WB_DONE;
        end
      end
      WB_PACK: begin
        feature_ready = 1'b1;
        if (pack_full) state_d = WB_WRITE;
      end
      WB_WRITE: begin
        o_feature_wr_en = 1'b1;
        o_data_bus_port = DATA_BUS_WIDTH'(pack_dat);
        o_feature_addr  = addr_q;
        if (o_mem_ready) begin
          beat_acc = 1'b1;
          addr_d   = addr_q + 1'b1;
          beats_d  = beats_q - 8'd1;
          state_d  = (beats_q == 8'd1) ? WB_DONE : WB_PACK;
        end
      end
      WB_DONE: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WB_IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      wb_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
      wb_done_q <= (state_q == WB_DONE);
    end
  end

  assign wb_done = wb_done_q;
  assign busy    = (state_q != WB_IDLE) || wb_done_q;

`ifdef WB_PERF_CNT_EN
  logic [15:0] beat_total_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_total_q <= '0;
    end else if (beat_acc && (beat_total_q != 16'hFFFF)) begin
      beat_total_q <= beat_total_q + 16'd1;
    end
  end

  assign wb_beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_o_feature_writeback.sv
// Directed bench for o_feature_writeback: inputs driven and outputs sampled on the falling edge.
module tb_o_feature_writeback;

  logic         clk;
  logic         rst;
  logic         wb_enable;
  logic [15:0]  dst_addr;
  logic [7:0]   wb_count;
  logic         feature_valid;
  logic [31:0]  scaled_feature;
  logic         feature_ready;
  logic [127:0] o_data_bus_port;
  logic [15:0]  o_feature_addr;
  logic         o_feature_wr_en;
  logic         o_mem_ready;
  logic         busy;
  logic         wb_done;
`ifdef WB_PERF_CNT_EN
  logic [15:0]  wb_beat_total;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  logic [15:0]  wq_addr[$];
  logic [127:0] wq_data[$];

  o_feature_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .wb_enable       (wb_enable),
    .dst_addr        (dst_addr),
    .wb_count        (wb_count),
    .feature_valid   (feature_valid),
    .scaled_feature  (scaled_feature),
    .feature_ready   (feature_ready),
    .o_data_bus_port (o_data_bus_port),
    .o_feature_addr  (o_feature_addr),
    .o_feature_wr_en (o_feature_wr_en),
    .o_mem_ready     (o_mem_ready),
    .busy            (busy),
    .wb_done         (wb_done)
`ifdef WB_PERF_CNT_EN
    ,
    .wb_beat_total   (wb_beat_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard of accepted beats and done pulses.
  always @(posedge clk) begin
    if (rst && o_feature_wr_en && o_mem_ready) begin
      wq_addr.push_back(o_feature_addr);
      wq_data.push_back(o_data_bus_port);
    end
    if (rst && wb_done) n_done++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [7:0] c);
    wb_enable = 1'b1;
    dst_addr  = a;
    wb_count  = c;
    @(negedge clk);
    wb_enable = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w);
    int k = 0;
    while (!feature_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("feed_rdy", feature_ready, 1);
    scaled_feature = w;
    feature_valid  = 1'b1;
    @(negedge clk);
    feature_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!wb_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", wb_done, 1);
    @(negedge clk);
  endtask

  initial begin
    int wi;
    int nd;
    rst = 1'b0; wb_enable = 1'b0; dst_addr = '0; wb_count = '0;
    feature_valid = 1'b0; scaled_feature = '0; o_mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", o_feature_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", wb_done, 0);
    chk("rst_ready", feature_ready, 0);
    chk("rst_data", o_data_bus_port, 0);
    chk("rst_addr", o_feature_addr, 0);
`ifdef WB_PERF_CNT_EN
    chk("rst_total", wb_beat_total, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Single beat, no backpressure
    wi = wq_addr.size(); nd = n_done;
    start(16'h0040, 8'd1);
    chk("t1_busy", busy, 1);
    feed(32'h11111111); feed(32'h22222222); feed(32'h33333333); feed(32'h44444444);
    chk("t1_wr_en", o_feature_wr_en, 1);
    chk("t1_addr", o_feature_addr, 16'h0040);
    chk("t1_data", o_data_bus_port, 128'h44444444_33333333_22222222_11111111);
    chk("t1_ready_wr", feature_ready, 0);
    @(negedge clk);
    chk("t1_wr_drop", o_feature_wr_en, 0);
    chk("t1_done_early", wb_done, 0);
    @(negedge clk);
    chk("t1_done", wb_done, 1);
    chk("t1_busy_done", busy, 1);
    @(negedge clk);
    chk("t1_done_1cyc", wb_done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_nwr", wq_addr.size() - wi, 1);
    chk("t1_sb_addr", wq_addr[wi], 16'h0040);
    chk("t1_sb_data", wq_data[wi], 128'h44444444_33333333_22222222_11111111);
    chk("t1_ndone", n_done - nd, 1);

    // Backpressure: memory not ready for 5 cycles
    wi = wq_addr.size();
    o_mem_ready = 1'b0;
    start(16'h0080, 8'd1);
    feed(32'hA0000001); feed(32'hA0000002); feed(32'hA0000003); feed(32'hA0000004);
    for (int i = 0; i < 5; i++) begin
      chk("t2_wr_en", o_feature_wr_en, 1);
      chk("t2_addr", o_feature_addr, 16'h0080);
      chk("t2_data", o_data_bus_port, 128'hA0000004_A0000003_A0000002_A0000001);
      chk("t2_ready", feature_ready, 0);
      @(negedge clk);
    end
    o_mem_ready = 1'b1;
    chk("t2_wr_en_last", o_feature_wr_en, 1);
    @(negedge clk);
    chk("t2_wr_drop", o_feature_wr_en, 0);
    wait_done();
    chk("t2_nwr", wq_addr.size() - wi, 1);

    // Zero beat count
    wi = wq_addr.size(); nd = n_done;
    start(16'h0010, 8'd0);
    chk("t4_busy", busy, 1);
    chk("t4_ready", feature_ready, 0);
    chk("t4_done_early", wb_done, 0);
    @(negedge clk);
    chk("t4_done", wb_done, 1);
    chk("t4_ready2", feature_ready, 0);
    @(negedge clk);
    chk("t4_done_1cyc", wb_done, 0);
    chk("t4_idle", busy, 0);
    chk("t4_nwr", wq_addr.size() - wi, 0);
    chk("t4_ndone", n_done - nd, 1);

    // Reset in the middle of packing
    start(16'h0100, 8'd1);
    feed(32'hDEAD0001); feed(32'hDEAD0002);
    rst = 1'b0;
    #1;
    chk("t5_ready", feature_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_wr_en", o_feature_wr_en, 0);
    chk("t5_done", wb_done, 0);
`ifdef WB_PERF_CNT_EN
    chk("t5_total", wb_beat_total, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wi = wq_addr.size(); nd = n_done;
    start(16'h0200, 8'd1);
    feed(32'h50000001); feed(32'h50000002); feed(32'h50000003); feed(32'h50000004);
    chk("t5_addr", o_feature_addr, 16'h0200);
    chk("t5_data", o_data_bus_port, 128'h50000004_50000003_50000002_50000001);
    wait_done();
    chk("t5_nwr", wq_addr.size() - wi, 1);
    chk("t5_ndone", n_done - nd, 1);

    // Three beats across the address wrap; a start while busy is ignored
    wi = wq_addr.size(); nd = n_done;
    start(16'hFFFE, 8'd3);
    feed(32'hC0000000);
    wb_enable = 1'b1; dst_addr = 16'h1234; wb_count = 8'd9;
    feed(32'hC0000001);
    wb_enable = 1'b0;
    for (int i = 2; i < 12; i++) feed(32'hC0000000 + i);
    wait_done();
    chk("t3_nwr", wq_addr.size() - wi, 3);
    if (wq_addr.size() - wi >= 3) begin
      chk("t3_addr0", wq_addr[wi], 16'hFFFE);
      chk("t3_addr1", wq_addr[wi+1], 16'hFFFF);
      chk("t3_addr2", wq_addr[wi+2], 16'h0000);
      chk("t3_data2", wq_data[wi+2], 128'hC000000B_C000000A_C0000009_C0000008);
    end
    repeat (10) @(negedge clk);
    chk("t3_no_extra", wq_addr.size() - wi, 3);
    chk("t3_idle", busy, 0);
    chk("t3_ndone", n_done - nd, 1);

    // Two-beat transfer
    wi = wq_addr.size();
    start(16'h0300, 8'd2);
    for (int i = 0; i < 8; i++) feed(32'hE0000000 + i);
    wait_done();
    chk("t6_nwr", wq_addr.size() - wi, 2);
    if (wq_addr.size() - wi >= 2) chk("t6_addr1", wq_addr[wi+1], 16'h0301);
`ifdef WB_PERF_CNT_EN
    chk("perf_total", wb_beat_total, 6);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
